// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor, one register stage per 4-bit group
module pipelined_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF,
  output logic             Z
);
  localparam int LAT = WIDTH / 4;

  // 4-bit lookahead group: returns {group carry-out, sum[3:0]}
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [3:0] p, g;
    logic c1, c2, c3, gg, pp;
    p  = a ^ b;
    g  = a & b;
    c1 = g[0] | (p[0] & c);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pp = &p;
    return {gg | (pp & c), p ^ {c3, c2, c1, c}};
  endfunction

  logic             advance;
  logic [WIDTH-1:0] beff;
  logic             c0;

  logic [WIDTH-1:0] a_i [LAT];
  logic [WIDTH-1:0] b_i [LAT];
  logic [WIDTH-1:0] s_x [LAT];
  logic [WIDTH-1:0] a_q [LAT];
  logic [WIDTH-1:0] b_q [LAT];
  logic [WIDTH-1:0] s_q [LAT];
  logic [LAT-1:0]   c_i, c_n, c_q, v_i, v_q;
  logic [WIDTH-1:0] sg;
  logic             ovf_q, z_q, ovf_n, z_n, msb_cin;

  assign beff     = sub ? ~B : B;
  assign c0       = sub | Cin;
  assign advance  = ~v_q[LAT-1] | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    if (k == 0) begin : g_src
      assign a_i[0]  = A;
      assign b_i[0]  = beff;
      assign c_i[0]  = c0;
      assign v_i[0]  = in_valid;
      assign s_x[0]  = WIDTH'(sg[3:0]);
    end else begin : g_src
      assign a_i[k]  = a_q[k-1];
      assign b_i[k]  = b_q[k-1];
      assign c_i[k]  = c_q[k-1];
      assign v_i[k]  = v_q[k-1];
      // keep the lower groups already resolved upstream, splice in this group's sum
      assign s_x[k]  = (s_q[k-1] & ({WIDTH{1'b1}} >> (WIDTH - 4*k)))
                     | (sg & (WIDTH'(4'hF) << (4*k)));
    end
    assign {c_n[k], sg[4*k +: 4]} = cla4(a_i[k][4*k +: 4], b_i[k][4*k +: 4], c_i[k]);
  end

  // carry into the MSB recovered from the MSB sum bit and its operands
  assign msb_cin = s_x[LAT-1][WIDTH-1] ^ a_i[LAT-1][WIDTH-1] ^ b_i[LAT-1][WIDTH-1];
  assign ovf_n   = msb_cin ^ c_n[LAT-1];
  assign z_n     = ~|s_x[LAT-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      z_q   <= 1'b1;
      for (int k = 0; k < LAT; k++) begin
        s_q[k] <= '0;
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (advance) begin
      v_q <= v_i;
      // data registers only move with a real beat so bubbles leave results untouched
      for (int k = 0; k < LAT; k++) begin
        if (v_i[k]) begin
          s_q[k] <= s_x[k];
          c_q[k] <= c_n[k];
          a_q[k] <= a_i[k];
          b_q[k] <= b_i[k];
        end
      end
      if (v_i[LAT-1]) begin
        ovf_q <= ovf_n;
        z_q   <= z_n;
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign S         = s_q[LAT-1];
  assign Cout      = c_q[LAT-1];
  assign OVF       = ovf_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - directed and randomized checks of pipelined_cla_adder against an arithmetic model
module tb_pipelined_cla_adder;
  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_ready, Cin, sub, out_valid, out_ready, Cout, OVF, Z;
  logic [WIDTH-1:0] A, B, S;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;
  exp_t e;
  logic stalled = 1'b0;

  pipelined_cla_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .OVF(OVF), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // integer arithmetic reference: signed range for OVF, unsigned range / compare for Cout
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
    int   sa, sbv, ua, ub, sr, ur;
    exp_t m;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    ua  = int'(a);
    ub  = int'(b);
    if (sb) begin
      sr  = sa - sbv;
      ur  = ua - ub;
      m.c = (ua >= ub);
    end else begin
      sr  = sa + sbv + int'(ci);
      ur  = ua + ub + int'(ci);
      m.c = (ur > 65535);
    end
    m.s = ur[15:0];
    m.o = (sr > 32767) || (sr < -32768);
    m.z = (m.s == 16'h0000);
    return m;
  endfunction

  always @(negedge clk) begin
    chk("in_ready_eq", in_ready, !out_valid || out_ready);
    if (!rst_n) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_S", S, held.s);
        chk("stall_flags", {Cout, OVF, Z}, {held.c, held.o, held.z});
      end
      stalled = out_valid && !out_ready;
      if (stalled) begin
        held = {S, Cout, OVF, Z};
        chk("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_S", S, e.s);
          chk("out_Cout", Cout, e.c);
          chk("out_OVF", OVF, e.o);
          chk("out_Z", Z, e.z);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(A, B, Cin, sub));
    end
  end

  task automatic single(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                        input logic [15:0] es, input logic ec, input logic eo, input logic ez);
    A = a; B = b; Cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    chk("single_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      chk("single_latency", out_valid, (i == LAT - 1));
      if (i == LAT - 1) begin
        chk("single_S", S, es);
        chk("single_flags", {Cout, OVF, Z}, {ec, eo, ez});
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    chk("single_drained", out_valid, 0);
  endtask

  task automatic stream(input int nb, input bit rnd, input int st_at, input int st_len,
                        output int nout, output int span);
    int sent = 0;
    int cyc  = 0;
    int first = 0;
    int last  = 0;
    bit acc;
    nout = 0;
    while ((sent < nb || exp_q.size() != 0) && cyc < 5000) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      else     out_ready = !(cyc >= st_at && cyc < st_at + st_len);
      if (sent < nb) begin
        if (rnd) begin
          in_valid = ($urandom_range(0, 9) < 7);
          A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
        end else begin
          in_valid = 1'b1;
          A = 16'(sent); B = 16'(sent << 4); Cin = 1'b0; sub = 1'b0;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (nout == 0) first = cyc;
        last = cyc;
        nout++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    span = last - first;
    chk("stream_timeout", cyc < 5000, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nout, span;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_S", S, 16'h0000);
    chk("rst_flags", {Cout, OVF, Z}, 3'b001);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_S", S, 16'h0000);
    chk("idle_Z", Z, 1);

    single(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    single(16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
    single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    single(16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    single(16'h0005, 16'h0008, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0);
    single(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    single(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    stream(8, 1'b0, 1000, 0, nout, span);
    chk("b2b_count", nout, 8);
    chk("b2b_consecutive", span, 7);

    stream(8, 1'b0, 6, 5, nout, span);
    chk("stall_count", nout, 8);
    chk("stall_span", span, 12);

    stream(300, 1'b1, 0, 0, nout, span);
    chk("rand_count", nout, 300);
    chk("drain_empty", exp_q.size(), 0);

    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
    end
    A = 16'h00FF; B = 16'h0001; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_S", S, 16'h0000);
    chk("flush_flags", {Cout, OVF, Z}, 3'b001);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("flush_quiet", out_valid, 0);
    end
    single(16'h4321, 16'h1111, 1'b0, 1'b1, 16'h3210, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
